// File: rtl/program_loader.sv
//==============================================================================
// Module   : program_loader
// Purpose  : Receives a program image over a valid/ready byte stream and
//            writes it into the SAP-1 program RAM, holding the core in reset
//            until a complete, legal image has been loaded.
//            Stream format: length byte N (1..2^ADDR_W), N data bytes and,
//            when PROGRAM_LOADER_CHECKSUM_EN is defined, one checksum byte
//            equal to the modulo-2^DATA_W sum of the data bytes.
// Macro    : PROGRAM_LOADER_CHECKSUM_EN - include the CHK state and sum logic.
// Ports    : clk        - clock, rising edge
//            clr        - asynchronous active-low reset
//            start      - request a new load session (ignored while busy)
//            rx_data    - stream byte
//            rx_valid   - rx_data qualifier
//            rx_ready   - loader accepts a byte this cycle
//            ram_we     - RAM write strobe (one-cycle pulse)
//            ram_addr   - RAM write address
//            ram_wdata  - RAM write data
//            cpu_clr    - active-low hold-in-reset for the core
//            busy/done/err - status flags
//            byte_count - data bytes written this session
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHK  = 3'd3,
`endif
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;     // next address to be written
  logic [CNT_W-1:0]    count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;   // address presented with ram_we
  logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  logic xfer;
  logic len_ok;
  logic last_byte;

  assign xfer      = rx_valid && rx_ready;
  // N must be non-zero and must fit in the RAM.
  assign len_ok    = (rx_data != '0) && (32'(rx_data) <= 32'(DEPTH));
  assign last_byte = ((count_q + CNT_W'(1)) == len_q);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          count_d = '0;
          addr_d  = '0;
          waddr_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LEN: begin
        if (xfer) begin
          if (len_ok) begin
            len_d   = CNT_W'(rx_data);
            state_d = DATA;
          end else begin
            state_d = ERR;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          // Write is registered: the strobe appears the cycle after accept.
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rx_data;
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
          if (last_byte) state_d = CHK;
`else
          if (last_byte) state_d = DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_d = (rx_data == sum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign busy = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
`else
  assign busy = (state_q == LEN) || (state_q == DATA);
`endif
  assign rx_ready   = busy;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  // Core is released only after a successful load.
  assign cpu_clr    = (state_q == DONE);
  assign ram_we     = we_q;
  assign ram_addr   = waddr_q;
  assign ram_wdata  = wdata_q;
  assign byte_count = count_q;

endmodule

`default_nettype wire
